aq_gemac_gmii_tx_arb: RTL and testbench

//  Shares the GMII transmit path feeding the GMII-to-RGMII converter between two frame

---
 rtl/aq_gemac_gmii_tx_arb_if.sv | 38 +++
 rtl/aq_gemac_gmii_tx_arb.sv | 154 +++++++++++++++
 tb/tb_aq_gemac_gmii_tx_arb.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aq_gemac_gmii_tx_arb_if.sv
// Bundle of the two frame-source ports, their grants and the muxed GMII transmit outputs.
// master: the side that owns the frame sources; slave: the arbiter.
interface aq_gemac_gmii_tx_arb_if;
  logic       en;
  logic       src0_req;
  logic [7:0] src0_txd;
  logic       src0_txe;
  logic       src0_txer;
  logic       src1_req;
  logic [7:0] src1_txd;
  logic       src1_txe;
  logic       src1_txer;
  logic       src0_gnt;
  logic       src1_gnt;
  logic [7:0] gmii_txd;
  logic       gmii_txe;
  logic       gmii_txer;
  logic       busy;
  logic       err_timeout;

  modport master (
    output en,
    output src0_req, src0_txd, src0_txe, src0_txer,
    output src1_req, src1_txd, src1_txe, src1_txer,
    input  src0_gnt, src1_gnt,
    input  gmii_txd, gmii_txe, gmii_txer,
    input  busy, err_timeout
  );

  modport slave (
    input  en,
    input  src0_req, src0_txd, src0_txe, src0_txer,
    input  src1_req, src1_txd, src1_txe, src1_txer,
    output src0_gnt, src1_gnt,
    output gmii_txd, gmii_txe, gmii_txer,
    output busy, err_timeout
  );
endinterface

// File: rtl/aq_gemac_gmii_tx_arb.sv
// GMII transmit arbiter: grants the MAC data path (src0) or the pause/control
// generator (src1) one frame at a time, enforces the inter-frame gap, revokes
// grants that never start, and flags bytes beyond the maximum frame length.
//
// state | meaning
// IDLE  | no owner; arbitrate among requesters when en=1
// GRANT | owner chosen, waiting for its first txe (bounded by START_TO)
// XFER  | owner's bytes forwarded to GMII with one cycle of latency
// IFG   | enforced idle gap before the next arbitration
module aq_gemac_gmii_tx_arb #(
  parameter int IFG_CYC  = 12,
  parameter int START_TO = 64,
  parameter int MAX_LEN  = 1526,
  parameter int PRIO1    = 0
) (
  input logic                   tx_clk,
  input logic                   rst_b,
  aq_gemac_gmii_tx_arb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT, XFER, IFG} state_e;

  localparam logic [7:0]  TO_LAST  = 8'(START_TO - 1);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_CYC - 1);
  localparam logic [15:0] LEN_MAX  = 16'(MAX_LEN);

  state_e      state_q;
  logic        sel_q;
  logic        last_q;
  logic        gnt0_q;
  logic        gnt1_q;
  logic [7:0]  wait_q;
  logic [7:0]  cnt_q;
  logic [15:0] len_q;
  logic [7:0]  txd_q;
  logic        txe_q;
  logic        txer_q;
  logic        err_q;

  logic        win_d;
  logic [15:0] len_d;
  logic        sel_req;
  logic        sel_txe;
  logic [7:0]  sel_txd;
  logic        sel_txer;
  logic        oversize;

  // Only the selected source's signals are ever looked at.
  assign sel_req  = sel_q ? bus.src1_req  : bus.src0_req;
  assign sel_txe  = sel_q ? bus.src1_txe  : bus.src0_txe;
  assign sel_txd  = sel_q ? bus.src1_txd  : bus.src0_txd;
  assign sel_txer = sel_q ? bus.src1_txer : bus.src0_txer;

  // len_q counts bytes already forwarded, so the byte being captured is len_q+1.
  assign oversize = (len_q >= LEN_MAX);
  assign len_d    = (&len_q) ? len_q : len_q + 16'd1;

  // Winner selection: lone requester wins; a tie goes to src1 in strict mode,
  // otherwise to whichever source was not granted last.
  always_comb begin
    win_d = 1'b0;
    if (bus.src0_req && bus.src1_req) begin
      win_d = (PRIO1 != 0) ? 1'b1 : ~last_q;
    end else begin
      win_d = bus.src1_req;
    end
  end

  // Arbitration FSM with registered grants and GMII outputs.
  always_ff @(posedge tx_clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      wait_q  <= 8'd0;
      cnt_q   <= 8'd0;
      len_q   <= 16'd0;
      txd_q   <= 8'd0;
      txe_q   <= 1'b0;
      txer_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // Outputs idle unless a byte is captured below.
      txd_q  <= 8'd0;
      txe_q  <= 1'b0;
      txer_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.en && (bus.src0_req || bus.src1_req)) begin
            sel_q   <= win_d;
            last_q  <= win_d;
            gnt0_q  <= ~win_d;
            gnt1_q  <= win_d;
            wait_q  <= 8'd0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (sel_txe) begin
            txd_q   <= sel_txd;
            txe_q   <= 1'b1;
            txer_q  <= sel_txer;
            len_q   <= 16'd1;
            state_q <= XFER;
          end else if (!sel_req) begin
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            state_q <= IDLE;
          end else if (wait_q == TO_LAST) begin
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        XFER: begin
          if (sel_txe) begin
            txd_q  <= sel_txd;
            txe_q  <= 1'b1;
            txer_q <= sel_txer | oversize;
            len_q  <= len_d;
          end else begin
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            cnt_q   <= IFG_LAST;
            state_q <= IFG;
          end
        end
        IFG: begin
          if (cnt_q == 8'd0) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.src0_gnt    = gnt0_q;
  assign bus.src1_gnt    = gnt1_q;
  assign bus.gmii_txd    = txd_q;
  assign bus.gmii_txe    = txe_q;
  assign bus.gmii_txer   = txer_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_aq_gemac_gmii_tx_arb.sv
// Bench for the GMII transmit arbiter: a cycle vector table, hand-written
// corner sequences, and a randomized two-source run scored at frame level.
module tb_aq_gemac_gmii_tx_arb;

  localparam int NF = 6;
  localparam int ML = 40;

  logic tx_clk;
  logic rst_b;
  int   checks = 0;
  int   errors = 0;

  aq_gemac_gmii_tx_arb_if bus ();
  aq_gemac_gmii_tx_arb_if bus_p ();

  aq_gemac_gmii_tx_arb #(.IFG_CYC(12), .START_TO(64), .MAX_LEN(1526), .PRIO1(0))
    dut (.tx_clk(tx_clk), .rst_b(rst_b), .bus(bus));

  aq_gemac_gmii_tx_arb #(.IFG_CYC(12), .START_TO(64), .MAX_LEN(1526), .PRIO1(1))
    dut_p (.tx_clk(tx_clk), .rst_b(rst_b), .bus(bus_p));

  initial tx_clk = 1'b0;
  always #4 tx_clk = ~tx_clk;

  typedef struct packed {
    logic       en;
    logic       r0;
    logic       e0;
    logic [7:0] d0;
    logic       x0;
    logic       r1;
    logic       e1;
    logic [7:0] d1;
    logic       x1;
    logic [7:0] reps;
    logic       g0;
    logic       g1;
    logic       ge;
    logic [7:0] gd;
    logic       gx;
    logic       bz;
    logic       er;
  } vec_t;

  vec_t tv [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.en = 1'b0;   bus.src0_req = 1'b0; bus.src0_txd = 8'h00; bus.src0_txe = 1'b0; bus.src0_txer = 1'b0;
    bus.src1_req = 1'b0; bus.src1_txd = 8'h00; bus.src1_txe = 1'b0; bus.src1_txer = 1'b0;
    bus_p.en = 1'b0; bus_p.src0_req = 1'b0; bus_p.src0_txd = 8'h00; bus_p.src0_txe = 1'b0; bus_p.src0_txer = 1'b0;
    bus_p.src1_req = 1'b0; bus_p.src1_txd = 8'h00; bus_p.src1_txe = 1'b0; bus_p.src1_txer = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge tx_clk);
    idle_inputs();
    rst_b = 1'b0;
    @(negedge tx_clk);
    rst_b = 1'b1;
  endtask

  // src0 sends one frame of len bytes on its own; counts output deviations.
  task automatic send0(input int len, output int lat, output int data_bad,
                       output int flag_bad, output int flagged);
    lat = 0; data_bad = 0; flag_bad = 0; flagged = 0;
    bus.en = 1'b1;
    bus.src0_req = 1'b1;
    do begin
      @(negedge tx_clk);
      lat++;
    end while (!bus.src0_gnt && lat < 10);
    for (int i = 1; i <= len; i++) begin
      bus.src0_txe  = 1'b1;
      bus.src0_txd  = 8'(i) ^ 8'h5A;
      bus.src0_txer = 1'b0;
      bus.src0_req  = 1'b0;
      @(negedge tx_clk);
      if (bus.gmii_txe !== 1'b1 || bus.gmii_txd !== (8'(i) ^ 8'h5A)) data_bad++;
      if (bus.gmii_txer !== (i >= 1527)) flag_bad++;
      if (bus.gmii_txer === 1'b1) flagged++;
    end
    bus.src0_txe = 1'b0;
    @(negedge tx_clk);
  endtask

  // Randomized-run storage and state.
  logic [7:0] rd [2][NF][ML];
  logic       rx [2][NF][ML];
  int         rl [2][NF];

  initial begin
    int lat, dbad, fbad, nflag, n;
    int s_f [2], s_idx [2], s_dly [2];
    bit s_act [2];
    logic o_req [2], o_e [2], o_x [2];
    logic [7:0] o_d [2];
    int m_cnt [2];
    int m_last, m_gap, m_k, m_own, m_bad, m_frames, m_fi, to_cnt, cyc;
    bit m_in;
    logic g;

    tv[0]  = '{1'b0,1'b1,1'b0,8'h00,1'b0, 1'b0,1'b0,8'h00,1'b0, 8'd1,  1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0};
    tv[1]  = '{1'b1,1'b1,1'b0,8'h00,1'b0, 1'b0,1'b0,8'h00,1'b0, 8'd1,  1'b1,1'b0,1'b0,8'h00,1'b0,1'b1,1'b0};
    tv[2]  = '{1'b1,1'b1,1'b1,8'hA1,1'b0, 1'b0,1'b0,8'h00,1'b0, 8'd1,  1'b1,1'b0,1'b1,8'hA1,1'b0,1'b1,1'b0};
    tv[3]  = '{1'b0,1'b0,1'b1,8'hB2,1'b1, 1'b1,1'b1,8'hFF,1'b0, 8'd1,  1'b1,1'b0,1'b1,8'hB2,1'b1,1'b1,1'b0};
    tv[4]  = '{1'b1,1'b0,1'b1,8'hC3,1'b0, 1'b1,1'b1,8'hEE,1'b1, 8'd1,  1'b1,1'b0,1'b1,8'hC3,1'b0,1'b1,1'b0};
    tv[5]  = '{1'b1,1'b0,1'b0,8'h00,1'b0, 1'b1,1'b0,8'h00,1'b0, 8'd1,  1'b0,1'b0,1'b0,8'h00,1'b0,1'b1,1'b0};
    tv[6]  = '{1'b1,1'b0,1'b0,8'h00,1'b0, 1'b1,1'b0,8'h00,1'b0, 8'd11, 1'b0,1'b0,1'b0,8'h00,1'b0,1'b1,1'b0};
    tv[7]  = '{1'b1,1'b0,1'b0,8'h00,1'b0, 1'b1,1'b0,8'h00,1'b0, 8'd1,  1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0};
    tv[8]  = '{1'b1,1'b0,1'b0,8'h00,1'b0, 1'b1,1'b0,8'h00,1'b0, 8'd1,  1'b0,1'b1,1'b0,8'h00,1'b0,1'b1,1'b0};
    tv[9]  = '{1'b1,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,8'h00,1'b0, 8'd1,  1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0};
    tv[10] = '{1'b1,1'b1,1'b0,8'h00,1'b0, 1'b1,1'b0,8'h00,1'b0, 8'd1,  1'b1,1'b0,1'b0,8'h00,1'b0,1'b1,1'b0};
    tv[11] = '{1'b1,1'b0,1'b0,8'h00,1'b0, 1'b1,1'b0,8'h00,1'b0, 8'd1,  1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0};
    tv[12] = '{1'b1,1'b1,1'b0,8'h00,1'b0, 1'b1,1'b0,8'h00,1'b0, 8'd1,  1'b0,1'b1,1'b0,8'h00,1'b0,1'b1,1'b0};
    tv[13] = '{1'b1,1'b1,1'b1,8'h99,1'b1, 1'b1,1'b1,8'h5A,1'b0, 8'd1,  1'b0,1'b1,1'b1,8'h5A,1'b0,1'b1,1'b0};
    tv[14] = '{1'b1,1'b1,1'b0,8'h00,1'b0, 1'b0,1'b0,8'h00,1'b0, 8'd1,  1'b0,1'b0,1'b0,8'h00,1'b0,1'b1,1'b0};

    // Reset state, with requests already asserted.
    rst_b = 1'b0;
    idle_inputs();
    bus.en = 1'b1; bus.src0_req = 1'b1; bus.src1_req = 1'b1;
    repeat (3) @(negedge tx_clk);
    chk("rst_gnt", {bus.src0_gnt, bus.src1_gnt}, 2'b00);
    chk("rst_gmii", {bus.gmii_txd, bus.gmii_txe, bus.gmii_txer}, 10'h000);
    chk("rst_busy_err", {bus.busy, bus.err_timeout}, 2'b00);

    // Cycle vector table.
    rst_b = 1'b1;
    for (int i = 0; i < 15; i++) begin
      for (int r = 0; r < int'(tv[i].reps); r++) begin
        bus.en = tv[i].en;
        bus.src0_req = tv[i].r0; bus.src0_txe = tv[i].e0; bus.src0_txd = tv[i].d0; bus.src0_txer = tv[i].x0;
        bus.src1_req = tv[i].r1; bus.src1_txe = tv[i].e1; bus.src1_txd = tv[i].d1; bus.src1_txer = tv[i].x1;
        @(negedge tx_clk);
        chk($sformatf("vec%0d_%0d_gnt", i, r), {bus.src0_gnt, bus.src1_gnt}, {tv[i].g0, tv[i].g1});
        chk($sformatf("vec%0d_%0d_gmii", i, r), {bus.gmii_txe, bus.gmii_txd, bus.gmii_txer},
            {tv[i].ge, tv[i].gd, tv[i].gx});
        chk($sformatf("vec%0d_%0d_busy_err", i, r), {bus.busy, bus.err_timeout}, {tv[i].bz, tv[i].er});
      end
    end

    // Single 60-byte frame from src0.
    do_reset();
    send0(60, lat, dbad, fbad, nflag);
    chk("f60_gnt_latency", lat, 1);
    chk("f60_data_bad", dbad, 0);
    chk("f60_txer_bad", fbad, 0);
    chk("f60_end", {bus.gmii_txe, bus.src0_gnt}, 2'b00);

    // Oversize frame: only output bytes 1527..1530 carry txer.
    do_reset();
    send0(1530, lat, dbad, fbad, nflag);
    chk("f1530_data_bad", dbad, 0);
    chk("f1530_txer_bad", fbad, 0);
    chk("f1530_flagged", nflag, 4);

    // Start timeout: src0 granted, never starts; src1 served afterwards.
    do_reset();
    bus.en = 1'b1; bus.src0_req = 1'b1; bus.src1_req = 1'b1;
    n = 0;
    do begin
      @(negedge tx_clk);
      n++;
    end while (!bus.src0_gnt && n < 5);
    chk("to_gnt0", {bus.src0_gnt, bus.src1_gnt}, 2'b10);
    n = 0;
    do begin
      @(negedge tx_clk);
      n++;
    end while (!bus.err_timeout && n < 200);
    chk("to_cycles", n, 64);
    chk("to_gnt_cleared", {bus.src0_gnt, bus.busy}, 2'b00);
    bus.src0_req = 1'b0;
    @(negedge tx_clk);
    chk("to_pulse_width", bus.err_timeout, 1'b0);
    chk("to_src1_served", {bus.src0_gnt, bus.src1_gnt}, 2'b01);
    bus.src1_req = 1'b0;
    @(negedge tx_clk);

    // Asynchronous reset in the middle of a frame.
    do_reset();
    bus.en = 1'b1; bus.src0_req = 1'b1;
    @(negedge tx_clk);
    bus.src0_txe = 1'b1; bus.src0_txd = 8'h11; bus.src1_req = 1'b1;
    @(negedge tx_clk);
    bus.src0_txd = 8'h22;
    @(negedge tx_clk);
    chk("arst_pre_txe", {bus.gmii_txe, bus.gmii_txd}, 9'h122);
    #2 rst_b = 1'b0;
    #1;
    chk("arst_gmii", {bus.gmii_txe, bus.gmii_txd, bus.gmii_txer}, 10'h000);
    chk("arst_gnt_busy", {bus.src0_gnt, bus.src1_gnt, bus.busy}, 3'b000);
    @(negedge tx_clk);
    bus.src0_txe = 1'b0;
    rst_b = 1'b1;
    @(negedge tx_clk);
    chk("arst_tie_src0", {bus.src0_gnt, bus.src1_gnt}, 2'b10);
    bus.src0_req = 1'b0; bus.src1_req = 1'b0;
    @(negedge tx_clk);

    // Strict src1 priority instance.
    do_reset();
    bus_p.en = 1'b1; bus_p.src0_req = 1'b1; bus_p.src1_req = 1'b1;
    for (int f = 0; f < 3; f++) begin
      n = 0;
      do begin
        @(negedge tx_clk);
        n++;
      end while (!(bus_p.src0_gnt || bus_p.src1_gnt) && n < 40);
      chk($sformatf("p1_f%0d_owner", f), {bus_p.src0_gnt, bus_p.src1_gnt}, 2'b01);
      for (int b = 0; b < 4; b++) begin
        bus_p.src1_txe = 1'b1;
        bus_p.src1_txd = 8'hA0 + 8'(b);
        @(negedge tx_clk);
      end
      chk($sformatf("p1_f%0d_last_byte", f), {bus_p.gmii_txe, bus_p.gmii_txd}, 9'h1A3);
      bus_p.src1_txe = 1'b0;
      if (f == 2) bus_p.src1_req = 1'b0;
      @(negedge tx_clk);
    end
    n = 0;
    do begin
      @(negedge tx_clk);
      n++;
    end while (!(bus_p.src0_gnt || bus_p.src1_gnt) && n < 40);
    chk("p1_src0_after_drop", {bus_p.src0_gnt, bus_p.src1_gnt}, 2'b10);
    bus_p.src0_req = 1'b0;
    @(negedge tx_clk);

    // Randomized two-source run scored against a frame-level model.
    for (int s = 0; s < 2; s++) begin
      for (int f = 0; f < NF; f++) begin
        rl[s][f] = $urandom_range(1, ML);
        for (int k = 0; k < ML; k++) begin
          rd[s][f][k] = 8'($urandom);
          rx[s][f][k] = ($urandom_range(0, 15) == 0);
        end
      end
      s_f[s] = 0; s_idx[s] = 0; s_dly[s] = 0; s_act[s] = 1'b0; m_cnt[s] = 0;
    end
    do_reset();
    m_last = 1; m_gap = 0; m_k = 0; m_own = 0; m_bad = 0; m_frames = 0; m_fi = 0;
    to_cnt = 0; m_in = 1'b0; cyc = 0;
    bus.src0_req = 1'b1; bus.src1_req = 1'b1; bus.en = 1'b1;
    while (!(m_cnt[0] >= NF && m_cnt[1] >= NF && !m_in) && cyc < 20000) begin
      @(negedge tx_clk);
      cyc++;
      if (bus.err_timeout === 1'b1) to_cnt++;
      if (bus.gmii_txe === 1'b1) begin
        if (!m_in) begin
          m_in = 1'b1; m_k = 0; m_bad = 0;
          if (m_cnt[0] < NF && m_cnt[1] < NF) m_own = 1 - m_last;
          else m_own = (m_cnt[0] < NF) ? 0 : 1;
          if (m_cnt[0] >= NF && m_cnt[1] >= NF) m_bad++;
          m_fi = (m_cnt[m_own] < NF) ? m_cnt[m_own] : NF - 1;
          if (m_frames > 0) begin
            checks++;
            if (m_gap < 13) begin
              errors++;
              $display("FAIL rnd_gap frame=%0d actual=%0d required>=13", m_frames, m_gap);
            end
          end
        end
        g = (m_own == 1) ? bus.src1_gnt : bus.src0_gnt;
        if (g !== 1'b1) m_bad++;
        if (m_k < rl[m_own][m_fi]) begin
          if (bus.gmii_txd !== rd[m_own][m_fi][m_k] || bus.gmii_txer !== rx[m_own][m_fi][m_k]) m_bad++;
        end else begin
          m_bad++;
        end
        m_k++;
        m_gap = 0;
      end else begin
        if (m_in) begin
          m_in = 1'b0;
          chk($sformatf("rnd_len_f%0d_src%0d", m_frames, m_own), m_k, rl[m_own][m_fi]);
          chk($sformatf("rnd_bytes_f%0d_src%0d", m_frames, m_own), m_bad, 0);
          m_cnt[m_own]++;
          m_last = m_own;
          m_frames++;
        end
        m_gap++;
      end
      // Source drivers: request while frames remain, start after a short random delay,
      // and drive noise whenever not granted.
      for (int s = 0; s < 2; s++) begin
        g = (s == 1) ? bus.src1_gnt : bus.src0_gnt;
        o_req[s] = (s_f[s] < NF);
        o_e[s] = 1'b0; o_d[s] = 8'h00; o_x[s] = 1'b0;
        if (s_f[s] < NF && !s_act[s] && g === 1'b1) begin
          s_act[s] = 1'b1;
          s_dly[s] = $urandom_range(0, 4);
          s_idx[s] = 0;
        end
        if (s_act[s]) begin
          if (s_dly[s] > 0) begin
            s_dly[s]--;
            o_d[s] = 8'($urandom);
          end else if (s_idx[s] < rl[s][s_f[s]]) begin
            o_e[s] = 1'b1;
            o_d[s] = rd[s][s_f[s]][s_idx[s]];
            o_x[s] = rx[s][s_f[s]][s_idx[s]];
            s_idx[s]++;
          end else begin
            s_act[s] = 1'b0;
            s_f[s]++;
            o_req[s] = (s_f[s] < NF);
          end
        end else begin
          o_e[s] = 1'($urandom_range(0, 1));
          o_d[s] = 8'($urandom);
          o_x[s] = 1'($urandom_range(0, 1));
        end
      end
      bus.en = ($urandom_range(0, 3) != 0);
      bus.src0_req = o_req[0]; bus.src0_txe = o_e[0]; bus.src0_txd = o_d[0]; bus.src0_txer = o_x[0];
      bus.src1_req = o_req[1]; bus.src1_txe = o_e[1]; bus.src1_txd = o_d[1]; bus.src1_txer = o_x[1];
    end
    chk("rnd_frames_src0", m_cnt[0], NF);
    chk("rnd_frames_src1", m_cnt[1], NF);
    chk("rnd_within_budget", (cyc < 20000), 1'b1);
    chk("rnd_no_timeout", to_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
